hd_controller: RTL and testbench
================================

HD_CONTROLLER -- requirements
Module: hd_controller

Interface
REQ-001 The block SHALL have parameter SEEK_CYC, default 4, meaning clock cycles to move the head one track.
REQ-002 The block SHALL have parameter SECTOR_CYC, default 2, meaning clock cycles per sector passing under the head.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req, input, 1 bit: access request, sampled only in IDLE.
REQ-006 The block SHALL have port write_en, input, 1 bit: 1 = write, 0 = read; qualified by req.
REQ-007 The block SHALL have port track, input, 3 bits: target track, driven by the processor's track output.
REQ-008 The block SHALL have port sector, input, 5 bits: target sector.
REQ-009 The block SHALL have port address_in_sector, input, 7 bits: word offset within the sector.
REQ-010 The block SHALL have port wdata, input, 32 bits: write data.
REQ-011 The block SHALL have port rdata, output, 32 bits: read data, valid when done=1 on a read.
REQ-012 The block SHALL have port busy, output, 1 bit: 1 in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse, feeding the processor's done/in_ready path.
REQ-014 The block SHALL have port head_track, output, 3 bits: current head position.

Function
REQ-015 Storage SHALL be 8 tracks x 32 sectors x 128 words x 32 bits, addressed {track, sector, address_in_sector}.
REQ-016 The FSM SHALL have states IDLE, SEEK, ROTATE, XFER and DONE.
REQ-017 In IDLE with req=1, the block SHALL latch track, sector, address_in_sector, write_en and wdata.
- It SHALL go to SEEK if the latched track differs from head_track; otherwise it SHALL go to ROTATE.
REQ-018 SEEK SHALL last exactly |track - head_track| * SEEK_CYC cycles.
- head_track SHALL step by 1 toward the target every SEEK_CYC cycles.
- On exit from SEEK, head_track SHALL equal the target track.
REQ-019 A free-running rotation model SHALL run in all states:
- a cycle counter wraps at SECTOR_CYC-1;
- on each wrap, cur_sector increments, wrapping 31 -> 0.
REQ-020 In ROTATE, the block SHALL go to XFER on the first cycle in which cur_sector equals the target sector.
REQ-021 XFER SHALL last 1 cycle.
- Write: memory is updated.
- Read: rdata is registered from memory.
REQ-022 DONE SHALL last 1 cycle with done=1, then return to IDLE.
- rdata SHALL hold its value until the next read completes.
REQ-023 req SHALL be ignored while busy=1; there is no queueing.
REQ-024 A write SHALL never modify any location other than the addressed one.

Reset
REQ-025 Asserting reset at any time SHALL force:
- state = IDLE, busy = 0, done = 0, rdata = 0;
- head_track = 0, cur_sector = 0, rotation counter = 0.
REQ-026 Reset during an operation SHALL abort it with no memory write; storage contents are not cleared by reset.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the geometry constants (TRACKS=8, SECTORS=32, WORDS=128, address width 15).
REQ-028 Storage SHALL be a single sub-module, disk_array: synchronous 32768x32 RAM with one read/write port.

Verification
REQ-029 Write/read-back: write 0xDEADBEEF to (3,17,5), then read (3,17,5) -> rdata = 0xDEADBEEF with done=1; (3,17,6) is unchanged.
REQ-030 Seek timing (SEEK_CYC=4): with head_track=0, request track 5 -> exactly 20 SEEK cycles, then head_track = 5; request track 5 again -> zero SEEK cycles.
REQ-031 Rotation wrap: request sector 0 while cur_sector = 31 -> ROTATE lasts until cur_sector wraps to 0, then XFER follows.
REQ-032 Busy collision: req pulse with a different address during SEEK -> ignored; exactly one done pulse; no second access.
REQ-033 Reset mid-write during ROTATE: target word retains its old value; busy = 0, head_track = 0 in the same cycle reset is asserted.
REQ-034 Back-to-back: req asserted the cycle after done -> accepted; busy rises on the next edge.

Source files
------------

// File: rtl/hd_controller_pkg.sv
// hd_controller_pkg
// Shared definitions for the disk controller slice: disk geometry, address
// and data widths, the controller FSM state encoding and the helper that
// forms a flat storage address from {track, sector, word}.
package hd_controller_pkg;

    localparam int TRACKS   = 8;
    localparam int SECTORS  = 32;
    localparam int WORDS    = 128;

    localparam int TRACK_W  = $clog2(TRACKS);
    localparam int SECTOR_W = $clog2(SECTORS);
    localparam int WORD_W   = $clog2(WORDS);
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEEK   = 3'd1,
        ST_ROTATE = 3'd2,
        ST_XFER   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Track is the most significant field, so a track is one contiguous
    // block of SECTORS*WORDS words.
    function automatic logic [ADDR_W-1:0] disk_addr(
        input logic [TRACK_W-1:0]  trk,
        input logic [SECTOR_W-1:0] sec,
        input logic [WORD_W-1:0]   word
    );
        return {trk, sec, word};
    endfunction

endpackage

// File: rtl/hd_controller_if.sv
// hd_controller_if
// Processor-side bus of the disk controller.
//   master (processor): drives req, write_en, track, sector,
//                       address_in_sector, wdata; sees rdata, busy, done,
//                       head_track.
//   slave  (controller): the mirror image.
interface hd_controller_if;
    import hd_controller_pkg::*;

    logic                req;
    logic                write_en;
    logic [TRACK_W-1:0]  track;
    logic [SECTOR_W-1:0] sector;
    logic [WORD_W-1:0]   address_in_sector;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic                busy;
    logic                done;
    logic [TRACK_W-1:0]  head_track;

    modport master (
        output req, write_en, track, sector, address_in_sector, wdata,
        input  rdata, busy, done, head_track
    );

    modport slave (
        input  req, write_en, track, sector, address_in_sector, wdata,
        output rdata, busy, done, head_track
    );

endinterface

// File: rtl/hd_controller_disk_array.sv
// disk_array
// Platter storage: synchronous single-port RAM, TRACKS*SECTORS*WORDS words
// of DATA_W bits. Reads are registered (data appears the cycle after the
// address). No reset: contents survive controller reset.
//   clk      : clock
//   we_i     : write enable for addr_i
//   addr_i   : flat word address {track, sector, word}
//   wdata_i  : write data
//   rdata_o  : registered read data (old contents on a write cycle)
module disk_array
    import hd_controller_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = TRACKS * SECTORS * WORDS;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hd_controller.sv
// hd_controller
// Disk controller: accepts one access at a time, moves the head track by
// track (SEEK_CYC cycles per track), waits for the target sector to come
// under the head on a free-running rotation model (SECTOR_CYC cycles per
// sector), performs a one-cycle transfer and pulses done for one cycle.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset (storage is not cleared)
//   bus   : processor bus, slave side (req/write_en/track/sector/
//           address_in_sector/wdata in; rdata/busy/done/head_track out)
module hd_controller
    import hd_controller_pkg::*;
#(
    parameter int SEEK_CYC   = 4,
    parameter int SECTOR_CYC = 2
)(
    input  logic            clk,
    input  logic            reset,
    hd_controller_if.slave  bus
);

    localparam int SEEK_W = (SEEK_CYC > 1) ? $clog2(SEEK_CYC) : 1;
    localparam int ROT_W  = (SECTOR_CYC > 1) ? $clog2(SECTOR_CYC) : 1;
    localparam logic [SEEK_W-1:0] SEEK_LAST = SEEK_W'(SEEK_CYC - 1);
    localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(SECTOR_CYC - 1);

    state_e              state_q, state_d;
    logic [SEEK_W-1:0]   seek_cnt_q, seek_cnt_d;
    logic [TRACK_W-1:0]  head_q, head_d;
    logic [ROT_W-1:0]    rot_cnt_q, rot_cnt_d;
    logic [SECTOR_W-1:0] cur_sector_q, cur_sector_d;
    logic [TRACK_W-1:0]  trk_q, trk_d;
    logic [SECTOR_W-1:0] sec_q, sec_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_rdata;

    // The RAM address is the latched request address for the whole
    // operation, so the registered RAM output already holds the target word
    // while in XFER and can be captured into rdata at the end of XFER.
    assign ram_addr = disk_addr(trk_q, sec_q, word_q);
    assign ram_we   = (state_q == ST_XFER) && wr_q;

    disk_array u_disk (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            seek_cnt_q   <= '0;
            head_q       <= '0;
            rot_cnt_q    <= '0;
            cur_sector_q <= '0;
            trk_q        <= '0;
            sec_q        <= '0;
            word_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            seek_cnt_q   <= seek_cnt_d;
            head_q       <= head_d;
            rot_cnt_q    <= rot_cnt_d;
            cur_sector_q <= cur_sector_d;
            trk_q        <= trk_d;
            sec_q        <= sec_d;
            word_q       <= word_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        seek_cnt_d   = seek_cnt_q;
        head_d       = head_q;
        rot_cnt_d    = rot_cnt_q + ROT_W'(1);
        cur_sector_d = cur_sector_q;
        trk_d        = trk_q;
        sec_d        = sec_q;
        word_d       = word_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;

        // Rotation runs regardless of FSM state; the sector counter wraps
        // 31 -> 0 by its natural width.
        if (rot_cnt_q == ROT_LAST) begin
            rot_cnt_d    = '0;
            cur_sector_d = cur_sector_q + SECTOR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    trk_d      = bus.track;
                    sec_d      = bus.sector;
                    word_d     = bus.address_in_sector;
                    wr_d       = bus.write_en;
                    wdata_d    = bus.wdata;
                    seek_cnt_d = '0;
                    state_d    = (bus.track != head_q) ? ST_SEEK : ST_ROTATE;
                end
            end
            ST_SEEK: begin
                // One head step at the end of every SEEK_CYC-cycle slot; the
                // slot that lands on the target also leaves SEEK.
                if (seek_cnt_q == SEEK_LAST) begin
                    seek_cnt_d = '0;
                    head_d     = (trk_q > head_q) ? head_q + TRACK_W'(1)
                                                  : head_q - TRACK_W'(1);
                    if (head_d == trk_q) begin
                        state_d = ST_ROTATE;
                    end
                end else begin
                    seek_cnt_d = seek_cnt_q + SEEK_W'(1);
                end
            end
            ST_ROTATE: begin
                if (cur_sector_q == sec_q) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!wr_q) begin
                    rdata_d = ram_rdata;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.rdata      = rdata_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.head_track = head_q;

endmodule

// File: tb/tb_hd_controller.sv
// tb_hd_controller
// Directed bench for hd_controller: write/read-back with neighbour words,
// seek timing, rotation wrap, request collision while busy, reset in the
// middle of a write, back-to-back requests. Expected completion cycles
// come from a reference rotation counter kept by the bench.
module tb_hd_controller;
    import hd_controller_pkg::*;

    localparam int SEEK_CYC   = 4;
    localparam int SECTOR_CYC = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    int tb_cyc;
    int acc_cyc;
    int exp_done_cyc;
    int seek_from;
    int seek_to;
    int seek_len;
    int head_exp;

    hd_controller_if bus ();

    hd_controller #(
        .SEEK_CYC   (SEEK_CYC),
        .SECTOR_CYC (SECTOR_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference for the free-running rotation: edges seen since reset.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    function automatic int exp_sector(input int c);
        return (c / SECTOR_CYC) % SECTORS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns at the negedge
    // right after the accepting edge.
    task automatic start_access(input logic wr, input int trk, input int sec,
                                input int word, input logic [31:0] data);
        int r;
        int j;
        chk("idle_before_req", bus.busy, 0);
        bus.req               = 1'b1;
        bus.write_en          = wr;
        bus.track             = TRACK_W'(trk);
        bus.sector            = SECTOR_W'(sec);
        bus.address_in_sector = WORD_W'(word);
        bus.wdata             = data;
        @(negedge clk);
        bus.req = 1'b0;
        acc_cyc = tb_cyc;
        chk("busy_after_accept", bus.busy, 1);
        seek_from = head_exp;
        seek_to   = trk;
        seek_len  = ((trk > head_exp) ? trk - head_exp : head_exp - trk) * SEEK_CYC;
        r = acc_cyc + seek_len;
        j = 0;
        while (exp_sector(r + j) != sec) j++;
        exp_done_cyc = r + j + 2;
        head_exp = trk;
        $display("access %s trk=%0d sec=%0d word=%0d data=0x%08h accepted at cyc %0d, done expected at cyc %0d",
                 wr ? "W" : "R", trk, sec, word, data, acc_cyc, exp_done_cyc);
    endtask

    task automatic finish_access(input logic check_rd, input logic [31:0] exp_rd);
        int n;
        int m;
        int eh;
        logic path_ok;
        n = 0;
        path_ok = 1'b1;
        while (bus.done !== 1'b1 && n < 300) begin
            m = tb_cyc - acc_cyc;
            if (m < seek_len)
                eh = (seek_from < seek_to) ? seek_from + m / SEEK_CYC
                                           : seek_from - m / SEEK_CYC;
            else
                eh = seek_to;
            if (bus.head_track !== TRACK_W'(eh)) path_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("done_seen", bus.done, 1);
        chk("head_path", path_ok, 1);
        chk("done_cycle", tb_cyc, exp_done_cyc);
        chk("head_at_done", bus.head_track, seek_to);
        if (check_rd) chk("rdata", bus.rdata, exp_rd);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("idle_after_done", bus.busy, 0);
    endtask

    task automatic access(input logic wr, input int trk, input int sec,
                          input int word, input logic [31:0] data);
        start_access(wr, trk, sec, word, wr ? data : 32'h0);
        finish_access(!wr, data);
    endtask

    task automatic wait_sector_next(input int s);
        int n;
        n = 0;
        while (exp_sector(tb_cyc + 1) != s && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int extra_done;
        int extra_busy;
        bus.req = 1'b0; bus.write_en = 1'b0; bus.track = '0; bus.sector = '0;
        bus.address_in_sector = '0; bus.wdata = '0;
        head_exp = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_head", bus.head_track, 0);
        reset = 1'b0;
        @(negedge clk);

        // Write/read-back with neighbours, back-to-back requests
        access(1'b1, 3, 17, 6, 32'h1234_5678);
        access(1'b1, 3, 17, 4, 32'hCAFE_F00D);
        access(1'b1, 3, 17, 5, 32'hDEAD_BEEF);
        access(1'b0, 3, 17, 5, 32'hDEAD_BEEF);
        access(1'b0, 3, 17, 6, 32'h1234_5678);
        access(1'b0, 3, 17, 4, 32'hCAFE_F00D);

        // Reset from idle clears rdata and the head
        reset = 1'b1;
        #1;
        chk("rst2_rdata", bus.rdata, 0);
        chk("rst2_head", bus.head_track, 0);
        @(negedge clk);
        reset = 1'b0;
        head_exp = 0;
        @(negedge clk);

        // Seek 0 -> 5 (20 cycles), then same track (no seek)
        access(1'b1, 5, 2, 9, 32'h0BAD_F00D);
        access(1'b0, 5, 2, 9, 32'h0BAD_F00D);

        // Rotation wrap: request sector 0 while sector 31 is under the head
        wait_sector_next(31);
        access(1'b1, 5, 0, 3, 32'h55AA_55AA);
        access(1'b0, 5, 0, 3, 32'h55AA_55AA);

        // Collision: second request during SEEK must be ignored
        start_access(1'b1, 2, 10, 7, 32'h600D_CAFE);
        bus.req = 1'b1; bus.write_en = 1'b1; bus.track = 3'd3; bus.sector = 5'd17;
        bus.address_in_sector = 7'd4; bus.wdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.req = 1'b0;
        finish_access(1'b0, 32'h0);
        extra_done = 0;
        extra_busy = 0;
        repeat (40) begin
            if (bus.done === 1'b1) extra_done++;
            if (bus.busy === 1'b1) extra_busy++;
            @(negedge clk);
        end
        chk("collision_no_done", extra_done, 0);
        chk("collision_no_busy", extra_busy, 0);

        // Reset mid-write while rotating towards sector 10
        wait_sector_next(12);
        start_access(1'b1, 2, 10, 7, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        chk("rotate_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_head", bus.head_track, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_rdata", bus.rdata, 0);
        @(negedge clk);
        reset = 1'b0;
        head_exp = 0;
        @(negedge clk);

        // Aborted write and ignored collision left storage untouched
        access(1'b0, 2, 10, 7, 32'h600D_CAFE);
        access(1'b0, 3, 17, 4, 32'hCAFE_F00D);
        access(1'b0, 3, 17, 6, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
